// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way write-back data cache: default geometry
// and the miss-handling FSM encoding.
package dcache_pkg;

  localparam int DEF_NUM_SETS = 32;
  localparam int DEF_LINE_W   = 256;
  localparam int WORD_W       = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MISS        = 3'd1,
    WRITEBACK   = 3'd2,
    REFILL      = 3'd3,
    REFILL_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_way_sram.sv
// One cache way: tag + line storage per set, synchronous write, asynchronous read.
// Contents are deliberately not reset; validity lives in flops in the parent.
module dcache_way_sram
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int INDEX_W  = 5,
  parameter int TAG_W    = 22
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] windex,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wline,
  input  logic [INDEX_W-1:0] rindex,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rline
);

  logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
  logic [LINE_W-1:0] line_mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[windex]  <= wtag;
      line_mem[windex] <= wline;
    end
  end

  assign rtag  = tag_mem[rindex];
  assign rline = line_mem[rindex];

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with LRU
// replacement and a single-outstanding-miss FSM toward a line-wide memory.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int LINE_W   = DEF_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [31:0]       p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o
);

  localparam int OFFSET_W   = $clog2(LINE_W / 8);
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = OFFSET_W - 2;

  logic                  request;
  logic                  is_write;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  unused_addr_bits;

  assign request   = p1_MemRead_i | p1_MemWrite_i;
  assign is_write  = p1_MemWrite_i;
  assign req_tag   = p1_addr_i[31 -: TAG_W];
  assign req_index = p1_addr_i[OFFSET_W +: INDEX_W];
  assign req_word  = p1_addr_i[2 +: WORD_SEL_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  state_t state, state_next;

  logic [NUM_SETS-1:0] valid [2];
  logic [NUM_SETS-1:0] dirty [2];
  logic [NUM_SETS-1:0] lru;

  logic               victim;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;

  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   way_tag  [2];
  logic [LINE_W-1:0]  way_line [2];
  logic [1:0]         way_we;
  logic [TAG_W-1:0]   wr_tag;
  logic [LINE_W-1:0]  wr_line;
  logic [1:0]         match;
  logic               hit;
  logic               hit_way;
  logic [LINE_W-1:0]  hit_line;
  logic [LINE_W-1:0]  merged_line;
  logic               refill_ack;

  // Outside IDLE the arrays are addressed by the latched miss, so a CPU that
  // drops or changes its request mid-miss cannot corrupt the fill.
  assign rd_index = (state == IDLE) ? req_index : miss_index;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way_sram #(
      .NUM_SETS(NUM_SETS),
      .LINE_W  (LINE_W),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
    ) u_sram (
      .clk   (clk_i),
      .we    (way_we[w]),
      .windex(rd_index),
      .wtag  (wr_tag),
      .wline (wr_line),
      .rindex(rd_index),
      .rtag  (way_tag[w]),
      .rline (way_line[w])
    );
    assign match[w] = valid[w][req_index] & (way_tag[w] == req_tag);
  end

  // Hits only resolve in IDLE; a freshly filled line is consumed on the cycle after REFILL_DONE.
  assign hit        = request & (state == IDLE) & (match[0] ^ match[1]);
  assign hit_way    = match[1];
  assign hit_line   = way_line[hit_way];
  assign p1_stall_o = request & ~hit;
  assign p1_data_o  = (hit && !is_write) ? hit_line[{req_word, 5'd0} +: WORD_W] : '0;
  assign refill_ack = (state == REFILL) & mem_ack_i;

  always_comb begin
    merged_line = hit_line;
    merged_line[{req_word, 5'd0} +: WORD_W] = p1_data_i;
  end

  always_comb begin
    way_we  = '0;
    wr_tag  = req_tag;
    wr_line = merged_line;
    if (refill_ack) begin
      way_we[victim] = 1'b1;
      wr_tag         = miss_tag;
      wr_line        = mem_data_i;
    end else if (hit && is_write) begin
      way_we[hit_way] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int w = 0; w < 2; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
      lru <= '0;
    end else begin
      if (hit) begin
        lru[req_index] <= ~hit_way;
        if (is_write) dirty[hit_way][req_index] <= 1'b1;
      end
      if (refill_ack) begin
        valid[victim][miss_index] <= 1'b1;
        dirty[victim][miss_index] <= 1'b0;
      end
    end
  end

  // Victim: first invalid way (way 0 first), else LRU; frozen for the whole miss.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      victim     <= 1'b0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else if (state == IDLE && request && !hit) begin
      victim     <= !valid[0][req_index] ? 1'b0 :
                    !valid[1][req_index] ? 1'b1 : lru[req_index];
      miss_tag   <= req_tag;
      miss_index <= req_index;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (request && !hit) state_next = MISS;
      MISS:        state_next = (valid[victim][miss_index] && dirty[victim][miss_index])
                                ? WRITEBACK : REFILL;
      WRITEBACK:   if (mem_ack_i) state_next = REFILL;
      REFILL:      if (mem_ack_i) state_next = REFILL_DONE;
      REFILL_DONE: state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {way_tag[victim], miss_index, {OFFSET_W{1'b0}}};
        mem_data_o   = way_line[victim];
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag, miss_index, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: a flat architectural memory plus an abstract
// MRU-ordered residency model predict load data, stall lengths and memory traffic.
module tb_dcache_2way;
  import dcache_pkg::*;

  localparam int NUM_SETS   = DEF_NUM_SETS;
  localparam int LINE_W     = DEF_LINE_W;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int WORDS      = LINE_W / 32;
  localparam logic [31:0] ALIAS = 32'(NUM_SETS * LINE_BYTES);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_wdata;
  logic [31:0]       mem_addr;
  logic              mem_enable;
  logic              mem_write;
  logic [31:0]       p1_wdata = '0;
  logic [31:0]       p1_addr = '0;
  logic              p1_read = 1'b0;
  logic              p1_write = 1'b0;
  logic [31:0]       p1_rdata;
  logic              p1_stall;

  dcache_2way #(.NUM_SETS(NUM_SETS), .LINE_W(LINE_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .mem_data_o   (mem_wdata),
    .mem_addr_o   (mem_addr),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .p1_data_i    (p1_wdata),
    .p1_addr_i    (p1_addr),
    .p1_MemRead_i (p1_read),
    .p1_MemWrite_i(p1_write),
    .p1_data_o    (p1_rdata),
    .p1_stall_o   (p1_stall)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mem_lat = 1;

  // Backing memory (written-back lines) and architectural store overlay.
  logic [LINE_W-1:0] mem_lines [logic [31:0]];
  logic [31:0]       ref_words [logic [31:0]];
  // Residency: per set up to two line addresses, index 0 = most recently used.
  logic [31:0]       res_line [NUM_SETS][2];
  int                res_cnt  [NUM_SETS];
  bit                dirty_lines [logic [31:0]];

  int                wb_cnt = 0;
  int                rf_cnt = 0;
  logic [31:0]       last_wb_addr = '0;
  logic [31:0]       last_rf_addr = '0;
  logic [LINE_W-1:0] last_wb_line = '0;
  logic [31:0]       cur_line = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    logic [31:0] line = a & ~32'(LINE_BYTES - 1);
    logic [31:0] k = (a % 32'(LINE_BYTES)) / 4;
    return (line == ALIAS) ? k : line + k;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] line = a & ~32'(LINE_BYTES - 1);
    logic [31:0] k = (a % 32'(LINE_BYTES)) / 4;
    logic [LINE_W-1:0] l;
    if (!mem_lines.exists(line)) return init_word(a);
    l = mem_lines[line];
    return l[k*32 +: 32];
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [31:0] wa = a & ~32'd3;
    if (ref_words.exists(wa)) return ref_words[wa];
    return mem_word(wa);
  endfunction

  function automatic logic [LINE_W-1:0] mem_line_of(logic [31:0] line);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = mem_word(line + 32'(k * 4));
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] ref_line_of(logic [31:0] line);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = ref_word(line + 32'(k * 4));
    return l;
  endfunction

  // Memory responder: ack after mem_lat idle cycles of a held request.
  initial begin
    int cnt = 0;
    logic [LINE_W-1:0] exp_line;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst_n && mem_enable) begin
        if (cnt >= mem_lat) begin
          cnt = 0;
          if (mem_write) begin
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_line = mem_wdata;
            exp_line = ref_line_of(mem_addr);
            tests++;
            if (mem_wdata !== exp_line) begin
              fails++;
              $display("FAIL wb_line @%h: got %h expected %h", mem_addr, mem_wdata, exp_line);
            end
            mem_lines[mem_addr] = mem_wdata;
          end else begin
            rf_cnt++;
            last_rf_addr = mem_addr;
            check("refill_addr", mem_addr, cur_line);
            mem_rdata = mem_line_of(mem_addr);
          end
          mem_ack = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Compare process: every out-of-reset cycle, load data against the architectural memory.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if ((p1_read || p1_write) && !p1_stall) begin
          if (p1_write) begin
            check("store_rdata_zero", p1_rdata, 32'd0);
            ref_words[p1_addr & ~32'd3] = p1_wdata;
          end else begin
            check("load_data", p1_rdata, ref_word(p1_addr));
          end
        end else begin
          check("idle_rdata_zero", p1_rdata, 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p1_read = 1'b0;
    p1_write = 1'b0;
    #1;
    check("rst_enable", 32'(mem_enable), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_stall", 32'(p1_stall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_words.delete();
    dirty_lines.delete();
    for (int s = 0; s < NUM_SETS; s++) res_cnt[s] = 0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int stalls, output logic [31:0] rdata);
    logic [31:0] line = addr & ~32'(LINE_BYTES - 1);
    int set_i = int'((addr / 32'(LINE_BYTES)) % 32'(NUM_SETS));
    bit is_hit = 1'b0;
    bit do_wb;
    int hit_pos = 0;
    int wb0 = wb_cnt;
    int rf0 = rf_cnt;
    int exp_stalls;
    for (int i = 0; i < res_cnt[set_i]; i++)
      if (res_line[set_i][i] == line) begin is_hit = 1'b1; hit_pos = i; end
    do_wb = !is_hit && res_cnt[set_i] == 2 && dirty_lines.exists(res_line[set_i][1]);
    exp_stalls = is_hit ? 0 : (do_wb ? 5 + 2 * mem_lat : 4 + mem_lat);
    cur_line = line;
    @(negedge clk);
    p1_read = rd;
    p1_write = wr;
    p1_addr = addr;
    p1_wdata = data;
    stalls = 0;
    #1;
    while (p1_stall && stalls <= 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls > 200) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout @%h: still stalled after %0d cycles, required release", addr, stalls);
    end
    rdata = p1_rdata;
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("refill_count", 32'(rf_cnt - rf0), is_hit ? 32'd0 : 32'd1);
    check("wb_count", 32'(wb_cnt - wb0), 32'(do_wb));
    if (is_hit) begin
      if (hit_pos == 1) begin
        res_line[set_i][1] = res_line[set_i][0];
        res_line[set_i][0] = line;
      end
    end else begin
      if (res_cnt[set_i] == 2) dirty_lines.delete(res_line[set_i][1]);
      if (res_cnt[set_i] >= 1) res_line[set_i][1] = res_line[set_i][0];
      res_line[set_i][0] = line;
      if (res_cnt[set_i] < 2) res_cnt[set_i]++;
    end
    if (wr) dirty_lines[line] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] rd;
    int guard;

    // Cold load, word k = k at the first aliasing line of set 0.
    do_reset();
    mem_lat = 1;
    access(1, 0, ALIAS + 4, 0, st, rd);
    check("cold_stall", 32'(st), 32'd5);
    check("cold_data", rd, 32'd1);
    check("cold_refill_addr", last_rf_addr, ALIAS);
    access(1, 0, ALIAS + 4, 0, st, rd);
    check("repeat_no_stall", 32'(st), 32'd0);

    // Two lines in set 0, then LRU eviction.
    do_reset();
    mem_lat = 0;
    access(1, 0, ALIAS, 0, st, rd);
    access(1, 0, 2 * ALIAS, 0, st, rd);
    access(1, 0, ALIAS, 0, st, rd);
    check("lru_hit_a", 32'(st), 32'd0);
    access(1, 0, 3 * ALIAS, 0, st, rd);
    check("evict_refill_addr", last_rf_addr, 3 * ALIAS);
    access(1, 0, ALIAS + 8, 0, st, rd);
    check("a_still_hits", 32'(st), 32'd0);
    access(1, 0, 2 * ALIAS, 0, st, rd);
    check("evicted_b_misses", 32'(st), 32'd4);

    // Dirty eviction and refill of written-back data.
    do_reset();
    mem_lat = 2;
    access(0, 1, ALIAS + 4, 32'hDEADBEEF, st, rd);
    access(1, 0, 2 * ALIAS, 0, st, rd);
    access(1, 0, 2 * ALIAS, 0, st, rd);
    access(1, 0, 3 * ALIAS, 0, st, rd);
    check("wb_stall", 32'(st), 32'd9);
    check("wb_addr", last_wb_addr, ALIAS);
    check("wb_word1", last_wb_line[32 +: 32], 32'hDEADBEEF);
    check("wb_then_refill", last_rf_addr, 3 * ALIAS);
    access(1, 0, ALIAS + 4, 0, st, rd);
    check("reload_data", rd, 32'hDEADBEEF);
    check("reload_refill_addr", last_rf_addr, ALIAS);

    // Read+write together is a store; last word of last set with a maximal tag.
    mem_lat = 1;
    access(1, 0, ALIAS + 8, 0, st, rd);
    access(1, 1, ALIAS + 8, 32'h12345678, st, rd);
    check("both_store_hit", 32'(st), 32'd0);
    access(1, 0, ALIAS + 8, 0, st, rd);
    check("both_store_data", rd, 32'h12345678);
    access(0, 1, 32'hFFFF_FFFC, 32'hA5A5_0F0F, st, rd);
    access(1, 0, 32'hFFFF_FFFC, 0, st, rd);
    check("edge_store_data", rd, 32'hA5A5_0F0F);
    access(1, 0, 32'hFFFF_FFE0, 0, st, rd);
    check("edge_word0", rd, 32'hFFFF_FFE0);

    // Reset asserted while a write-back is outstanding.
    do_reset();
    mem_lat = 1;
    access(0, 1, ALIAS + 4, 32'hCAFEF00D, st, rd);
    access(1, 0, 2 * ALIAS, 0, st, rd);
    mem_lat = 50;
    @(negedge clk);
    p1_read = 1'b1;
    p1_write = 1'b0;
    p1_addr = 3 * ALIAS;
    guard = 0;
    #1;
    while (!(mem_enable && mem_write) && guard < 20) begin
      guard++;
      @(negedge clk);
      #1;
    end
    check("wb_started", 32'(mem_enable && mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_enable", 32'(mem_enable), 32'd0);
    check("async_rst_write", 32'(mem_write), 32'd0);
    check("async_rst_addr", mem_addr, 32'd0);
    check("async_rst_stall", 32'(p1_stall), 32'd1);
    check("async_rst_rdata", p1_rdata, 32'd0);
    check("no_wb_completed", 32'(mem_lines[ALIAS][32 +: 32]), 32'hDEADBEEF);
    do_reset();
    mem_lat = 1;
    access(1, 0, ALIAS + 4, 0, st, rd);
    check("post_rst_miss", 32'(st), 32'd5);
    check("post_rst_data", rd, 32'hDEADBEEF);

    @(negedge clk);
    p1_read = 1'b0;
    p1_write = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter NUM_SETS, default 32, meaning number of sets (power of two, >= 2).
REQ-002 SHALL have parameter LINE_W, default 256, meaning cache line and memory bus width in bits (power of two, >= 64).
REQ-003 SHALL derive OFFSET_W = log2(LINE_W/8), INDEX_W = log2(NUM_SETS), TAG_W = 32-INDEX_W-OFFSET_W; word is fixed at 32 bits.
REQ-004 SHALL have the following ports:
- clk_i  in  1  single clock, rising edge; one clock, reset asynchronous active-low.
- rst_i  in  1  asynchronous active-low reset.
- mem_data_i  in  LINE_W  refill line from data memory.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- mem_data_o  out  LINE_W  write-back line.
- mem_addr_o  out  32  line-aligned memory address.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- p1_data_i  in  32  CPU store data.
- p1_addr_i  in  32  CPU byte address; bits [1:0] ignored.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; wins if both asserted.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  CPU must hold request stable.

Function
REQ-005 SHALL be 2-way set-associative, write-back, write-allocate; per way per set: valid, dirty, tag, line; per set: one LRU bit naming the least-recently-used way.
REQ-006 SHALL split the address as tag = [31:INDEX_W+OFFSET_W], index = [INDEX_W+OFFSET_W-1:OFFSET_W], word = [OFFSET_W-1:2].
REQ-007 SHALL compute hit combinationally: hit = a request is present and (valid & tag match) holds in exactly one way; a double match SHALL never arise.
REQ-008 SHALL drive p1_stall_o = request & ~hit, combinationally, in every state.
REQ-009 SHALL return the selected 32-bit word of the hit way on p1_data_o in the same cycle as a read hit; otherwise p1_data_o = 0.
REQ-010 SHALL, on the clock edge of a write hit, replace only the selected word of the hit way and set that way's dirty bit.
REQ-011 SHALL, on every hit edge, set LRU to the way that did not hit.
REQ-012 SHALL implement the FSM states IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
REQ-013 SHALL make these transitions:
- IDLE -> MISS on a request with no hit.
- MISS -> WRITEBACK if the victim is valid and dirty; otherwise MISS -> REFILL.
- WRITEBACK -> REFILL on mem_ack_i.
- REFILL -> REFILL_DONE on mem_ack_i.
- REFILL_DONE -> IDLE.
REQ-014 SHALL choose and latch the victim on entry to MISS: first invalid way (way 0 preferred), else the LRU way; the victim stays fixed until IDLE.
REQ-015 SHALL, in WRITEBACK, hold mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, OFFSET_W zeros}, mem_data_o = victim line, all stable until ack.
REQ-016 SHALL, in REFILL, hold mem_enable_o=1, mem_write_o=0, mem_addr_o = {request tag, index, zeros}.
REQ-017 SHALL, on the ack edge in REFILL, write mem_data_i into the victim and set its tag, valid=1, dirty=0; the hit then resolves in IDLE, with stores completing as a write hit.
REQ-018 SHALL ignore mem_ack_i in IDLE, MISS and REFILL_DONE; mem_enable_o = 0 in those states.
REQ-019 SHALL leave a request deasserted while not in IDLE as a legal CPU protocol violation: the fill completes and no store occurs.

Reset
REQ-020 SHALL, on rst_i low at any time (including mid-WRITEBACK or REFILL), immediately force the following; line/tag storage is not cleared:
- state = IDLE;
- mem_enable_o = 0, mem_write_o = 0;
- all valid, dirty and LRU bits = 0.
REQ-021 SHALL drive, during reset, mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0 and p1_stall_o = request (always a miss).

Structure
REQ-022 SHALL place the FSM state encoding and the default NUM_SETS/LINE_W constants in the shared dcache package.
REQ-023 SHALL instantiate the sub-module dcache_way_sram once per way: a synchronous-write, asynchronous-read tag+line array indexed by set.
REQ-024 SHALL keep valid, dirty and LRU in flops inside dcache_2way so that reset clears them.

Verification
REQ-025 Cold load 0x0000_0404, memory line with word k = k -> one refill at 0x0000_0400, stall for 4 cycles after ack latency, p1_data_o = 1; repeat load -> no stall.
REQ-026 Loads 0x400 then 0x800 (same set 0) -> both resident; load 0x400 again -> hit; load 0xC00 -> evicts way holding 0x800 (LRU), and 0x400 still hits.
REQ-027 Store 0xDEADBEEF to 0x404, load 0x800, load 0x800, load 0xC00 -> write-back at addr 0x400 with word 1 = 0xDEADBEEF, then refill at 0xC00; load 0x404 -> refill, data 0xDEADBEEF.
REQ-028 MemRead and MemWrite both 1 at 0x408 with data 0x12345678 on a hit -> store performed; next load returns 0x12345678.
REQ-029 rst_i low during WRITEBACK before ack -> mem_enable_o = 0 asynchronously; after release, a load of 0x404 misses and refills.
REQ-030 NUM_SETS=64, LINE_W=512 build -> REQ-025 to REQ-027 pass with addresses rescaled (set 0 alias stride 0x1000).
